// File: rtl/xnor_mask_eval_pipe.sv
// Two-stage valid/ready pipeline evaluating y = ~(e ^ m) bitwise over WIDTH lanes.
// Optional output toggle counter enabled by defining TOGGLE_CNT_EN.
module xnor_mask_eval_pipe #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] n_1,
   input  logic [WIDTH-1:0] n_2,
   input  logic [WIDTH-1:0] n_3,
   input  logic [WIDTH-1:0] n_4,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] n_9,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] toggle_cnt
);

   logic             s1_v_q, s1_v_d;
   logic             s2_v_q, s2_v_d;
   logic [WIDTH-1:0] e_q, e_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             s2_load;

   assign in_ready  = ~s1_v_q | ~s2_v_q | out_ready;
   assign s2_load   = ~s2_v_q | out_ready;
   assign out_valid = s2_v_q;
   assign n_9       = y_q;

   // Data registers only load on valid beats so bubbles do not disturb held values.
   always_comb begin
      s1_v_d = s1_v_q;
      e_d    = e_q;
      m_d    = m_q;
      s2_v_d = s2_v_q;
      y_d    = y_q;
      if (in_ready) begin
         s1_v_d = in_valid;
         if (in_valid) begin
            e_d = ~(n_2 ^ n_3);
            m_d = ~n_4 & ~(~n_3 & ~(n_1 ^ n_2));
         end
      end
      if (s2_load) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            y_d = ~(e_q ^ m_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         e_q    <= '0;
         m_q    <= '0;
         y_q    <= '0;
      end else begin
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         e_q    <= e_d;
         m_q    <= m_d;
         y_q    <= y_d;
      end
   end

`ifdef TOGGLE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] y_prev_q, y_prev_d;
   logic [CNT_W:0]   pop;
   logic [CNT_W:0]   sum;
   logic [WIDTH-1:0] diff;
   logic             out_xfer;

   assign out_xfer   = s2_v_q & out_ready;
   assign diff       = y_q ^ y_prev_q;
   assign toggle_cnt = cnt_q;

   always_comb begin
      pop = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         pop = pop + {{CNT_W{1'b0}}, diff[i]};
      end
   end

   // One spare bit catches overflow so the count saturates instead of wrapping.
   assign sum = {1'b0, cnt_q} + pop;

   always_comb begin
      cnt_d    = cnt_q;
      y_prev_d = y_prev_q;
      if (out_xfer) begin
         y_prev_d = y_q;
         cnt_d    = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         y_prev_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         y_prev_q <= y_prev_d;
      end
   end
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign toggle_cnt     = '0;
`endif

endmodule
